// File: rtl/priority_request_conditioner.sv
// ---------------------------------------------------------------------------
// priority_request_conditioner
//
// Input-conditioning stage that sits directly in front of the 8-bit priority
// encoder / 7-segment decoder. Each of the eight raw request lines is passed
// through a two-flop synchroniser and then a per-bit debouncer. The result is
// either forwarded live or captured in a latch that holds requests until
// they are acknowledged. The latch clears the highest-priority request first.
//
// Ports:
//   clk        in   1  clock; all logic on the rising edge
//   rst        in   1  synchronous, active-high reset
//   raw_in     in   8  asynchronous raw request lines (switches/buttons)
//   sticky_en  in   1  1 = latched-request mode, 0 = live debounced mode
//   ack        in   1  one-cycle pulse; clears highest latched request
//   data_out   out  8  conditioned requests (bit 7 = highest priority)
//   valid      out  1  any bit of data_out set
//   changed    out  1  registered one-cycle pulse after data_out changes
// ---------------------------------------------------------------------------
module priority_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_in,
  input  logic       sticky_en,
  input  logic       ack,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       changed
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [7:0]       s1_q, s1_d;
  logic [7:0]       s2_q, s2_d;
  logic [7:0]       deb_q, deb_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       latch_q, latch_d;
  logic [7:0]       prev_q, prev_d;
  logic             changed_q, changed_d;

  logic [7:0]       rise;
  logic [7:0]       clr_mask;

  // Synchroniser and per-bit debounce. A bit's count only advances while the
  // synchronised level disagrees with the accepted level; any return to
  // agreement throws the partial count away, so short pulses never land.
  always_comb begin
    s1_d  = raw_in;
    s2_d  = s1_q;
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Request latch. The ascending scan leaves only the highest set bit in the
  // clear mask. A rise on the same edge is OR-ed in after the clear, so a new
  // press always survives a simultaneous acknowledge. In live mode the latch
  // is held empty, so entering sticky mode never inherits stale requests.
  always_comb begin
    rise     = deb_d & ~deb_q;
    clr_mask = '0;
    if (ack) begin
      for (int i = 0; i < 8; i++) begin
        if (latch_q[i]) begin
          clr_mask = 8'b1 << i;
        end
      end
    end
    if (sticky_en) begin
      latch_d = (latch_q & ~clr_mask) | rise;
    end else begin
      latch_d = '0;
    end
  end

  // Output mux is purely combinational on registered sources, so a mode
  // toggle takes effect in the same cycle.
  always_comb begin
    data_out  = sticky_en ? latch_q : deb_q;
    valid     = |data_out;
    prev_d    = data_out;
    changed_d = (data_out != prev_q);
    changed   = changed_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= '0;
      latch_q   <= '0;
      prev_q    <= '0;
      changed_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      deb_q     <= deb_d;
      latch_q   <= latch_d;
      prev_q    <= prev_d;
      changed_q <= changed_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_priority_request_conditioner.sv
// ---------------------------------------------------------------------------
// tb_priority_request_conditioner
//
// Table-driven bench for priority_request_conditioner with the default
// debounce length of 4 (6-edge raw-to-output latency). Each table record
// holds a set of inputs for a number of rising edges, together with the
// data_out/changed values expected after each of those edges. A few
// hand-written steps check the same-cycle effect of toggling sticky_en.
// ---------------------------------------------------------------------------
module tb_priority_request_conditioner;

  typedef struct {
    string      name;
    logic       rst;
    logic       sticky;
    logic       ack;
    logic [7:0] raw;
    int         n;
    logic [7:0] exp_data;
    logic       exp_changed;
  } vec_t;

  typedef struct packed {
    logic [7:0] data;
    logic       changed;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] raw_in;
  logic       sticky_en;
  logic       ack;
  logic [7:0] data_out;
  logic       valid;
  logic       changed;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks;
  int   errors;

  priority_request_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .sticky_en (sticky_en),
    .ack       (ack),
    .data_out  (data_out),
    .valid     (valid),
    .changed   (changed)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the run ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input string name, input logic r, input logic s,
                        input logic a, input logic [7:0] raw, input int n,
                        input logic [7:0] d, input logic c);
    vec_t v;
    v.name        = name;
    v.rst         = r;
    v.sticky      = s;
    v.ack         = a;
    v.raw         = raw;
    v.n           = n;
    v.exp_data    = d;
    v.exp_changed = c;
    vecs.push_back(v);
  endtask

  // Compare the visible outputs against expected data_out/changed; valid is
  // expected to be the OR of the expected data.
  task automatic checkOutput(input string name, input logic [7:0] exp_data,
                             input logic exp_changed);
    checks++;
    if (data_out !== exp_data) begin
      errors++;
      $display("[TB] FAIL %s data_out: got %h expected %h", name, data_out, exp_data);
    end
    checks++;
    if (valid !== (|exp_data)) begin
      errors++;
      $display("[TB] FAIL %s valid: got %b expected %b", name, valid, |exp_data);
    end
    checks++;
    if (changed !== exp_changed) begin
      errors++;
      $display("[TB] FAIL %s changed: got %b expected %b", name, changed, exp_changed);
    end
  endtask

  // Drive one record's inputs and, for each edge it covers, queue the
  // expectation, clock, then pop and compare just after the edge.
  task automatic applyStimulus(input vec_t v);
    exp_t e;
    rst       = v.rst;
    sticky_en = v.sticky;
    ack       = v.ack;
    raw_in    = v.raw;
    for (int k = 0; k < v.n; k++) begin
      e.data    = v.exp_data;
      e.changed = v.exp_changed;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      checkOutput(v.name, e.data, e.changed);
    end
  endtask

  task automatic runRange(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      applyStimulus(vecs[i]);
    end
  endtask

  initial begin
    int mark_a;
    int mark_b;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    raw_in    = 8'h00;
    sticky_en = 1'b0;
    ack       = 1'b0;

    // Reset with all inputs high, then 6-edge acceptance and one pulse.
    addVec("t1_reset",     1, 0, 0, 8'hFF, 2, 8'h00, 0);
    addVec("t1_wait",      0, 0, 0, 8'hFF, 5, 8'h00, 0);
    addVec("t1_accept",    0, 0, 0, 8'hFF, 1, 8'hFF, 0);
    addVec("t1_pulse",     0, 0, 0, 8'hFF, 1, 8'hFF, 1);
    addVec("t1_hold",      0, 0, 0, 8'hFF, 2, 8'hFF, 0);
    // Live mode 0x00 -> 0x81 -> 0x00.
    addVec("t2_reset",     1, 0, 0, 8'h00, 2, 8'h00, 0);
    addVec("t2_idle",      0, 0, 0, 8'h00, 3, 8'h00, 0);
    addVec("t2_wait",      0, 0, 0, 8'h81, 5, 8'h00, 0);
    addVec("t2_accept",    0, 0, 0, 8'h81, 1, 8'h81, 0);
    addVec("t2_pulse",     0, 0, 0, 8'h81, 1, 8'h81, 1);
    addVec("t2_hold",      0, 0, 0, 8'h81, 2, 8'h81, 0);
    addVec("t2_rel_wait",  0, 0, 0, 8'h00, 5, 8'h81, 0);
    addVec("t2_rel",       0, 0, 0, 8'h00, 1, 8'h00, 0);
    addVec("t2_rel_pulse", 0, 0, 0, 8'h00, 1, 8'h00, 1);
    addVec("t2_rel_hold",  0, 0, 0, 8'h00, 2, 8'h00, 0);
    // Glitch of 3 cycles is rejected.
    addVec("t3_glitch",    0, 0, 0, 8'h08, 3, 8'h00, 0);
    addVec("t3_glitch_lo", 0, 0, 0, 8'h00, 6, 8'h00, 0);
    // Dropout restarts the count; acceptance 6 edges after it ends.
    addVec("t3_pre",       0, 0, 0, 8'h08, 1, 8'h00, 0);
    addVec("t3_dropout",   0, 0, 0, 8'h00, 1, 8'h00, 0);
    addVec("t3_wait",      0, 0, 0, 8'h08, 5, 8'h00, 0);
    addVec("t3_accept",    0, 0, 0, 8'h08, 1, 8'h08, 0);
    addVec("t3_pulse",     0, 0, 0, 8'h08, 1, 8'h08, 1);
    addVec("t3_hold",      0, 0, 0, 8'h08, 1, 8'h08, 0);
    addVec("t3_rel_wait",  0, 0, 0, 8'h00, 5, 8'h08, 0);
    addVec("t3_rel",       0, 0, 0, 8'h00, 1, 8'h00, 0);
    addVec("t3_rel_pulse", 0, 0, 0, 8'h00, 1, 8'h00, 1);
    addVec("t3_rel_hold",  0, 0, 0, 8'h00, 2, 8'h00, 0);
    // Sticky mode: latch bit5 then bit2, release, ack them off in order.
    addVec("t4_b5_wait",   0, 1, 0, 8'h20, 5, 8'h00, 0);
    addVec("t4_b5_set",    0, 1, 0, 8'h20, 1, 8'h20, 0);
    addVec("t4_b5_pulse",  0, 1, 0, 8'h20, 1, 8'h20, 1);
    addVec("t4_b5_hold",   0, 1, 0, 8'h20, 3, 8'h20, 0);
    addVec("t4_b5_rel",    0, 1, 0, 8'h00, 10, 8'h20, 0);
    addVec("t4_b2_wait",   0, 1, 0, 8'h04, 5, 8'h20, 0);
    addVec("t4_b2_set",    0, 1, 0, 8'h04, 1, 8'h24, 0);
    addVec("t4_b2_pulse",  0, 1, 0, 8'h04, 1, 8'h24, 1);
    addVec("t4_b2_hold",   0, 1, 0, 8'h04, 3, 8'h24, 0);
    addVec("t4_b2_rel",    0, 1, 0, 8'h00, 10, 8'h24, 0);
    addVec("t4_ack1",      0, 1, 1, 8'h00, 1, 8'h04, 0);
    addVec("t4_ack1_pls",  0, 1, 0, 8'h00, 1, 8'h04, 1);
    addVec("t4_ack2",      0, 1, 1, 8'h00, 1, 8'h00, 0);
    addVec("t4_ack2_pls",  0, 1, 0, 8'h00, 1, 8'h00, 1);
    addVec("t4_ack3",      0, 1, 1, 8'h00, 1, 8'h00, 0);
    addVec("t4_ack3_none", 0, 1, 0, 8'h00, 2, 8'h00, 0);
    // Set/clear collision: rise of bit4 on the same edge as ack.
    addVec("t5_b4_wait",   0, 1, 0, 8'h10, 5, 8'h00, 0);
    addVec("t5_b4_set",    0, 1, 0, 8'h10, 1, 8'h10, 0);
    addVec("t5_b4_pulse",  0, 1, 0, 8'h10, 1, 8'h10, 1);
    addVec("t5_b4_hold",   0, 1, 0, 8'h10, 3, 8'h10, 0);
    addVec("t5_b4_rel",    0, 1, 0, 8'h00, 10, 8'h10, 0);
    addVec("t5_re_wait",   0, 1, 0, 8'h10, 5, 8'h10, 0);
    addVec("t5_collide",   0, 1, 1, 8'h10, 1, 8'h10, 0);
    addVec("t5_no_pulse",  0, 1, 0, 8'h10, 4, 8'h10, 0);
    addVec("t5_rel",       0, 1, 0, 8'h00, 10, 8'h10, 0);
    // Build latch = 0xC0 for the mode-toggle check.
    addVec("t6_clear",     0, 1, 1, 8'h00, 1, 8'h00, 0);
    addVec("t6_clear_pls", 0, 1, 0, 8'h00, 1, 8'h00, 1);
    addVec("t6_c0_wait",   0, 1, 0, 8'hC0, 5, 8'h00, 0);
    addVec("t6_c0_set",    0, 1, 0, 8'hC0, 1, 8'hC0, 0);
    addVec("t6_c0_pulse",  0, 1, 0, 8'hC0, 1, 8'hC0, 1);
    addVec("t6_c0_hold",   0, 1, 0, 8'hC0, 3, 8'hC0, 0);
    addVec("t6_c0_rel",    0, 1, 0, 8'h00, 10, 8'hC0, 0);
    mark_a = vecs.size();
    // Live mode after leaving sticky: the drop to 0x00 pulses changed.
    addVec("t6_live_pls",  0, 0, 0, 8'h00, 1, 8'h00, 1);
    addVec("t6_live_hold", 0, 0, 0, 8'h00, 1, 8'h00, 0);
    mark_b = vecs.size();
    // Re-enabled sticky stays empty; then reset in a half-counted debounce.
    addVec("t6_sticky",    0, 1, 0, 8'h00, 3, 8'h00, 0);
    addVec("t6_half",      0, 0, 0, 8'h02, 4, 8'h00, 0);
    addVec("t6_rst",       1, 0, 0, 8'h02, 1, 8'h00, 0);
    addVec("t6_rst_wait",  0, 0, 0, 8'h02, 5, 8'h00, 0);
    addVec("t6_rst_acc",   0, 0, 0, 8'h02, 1, 8'h02, 0);
    addVec("t6_rst_pls",   0, 0, 0, 8'h02, 1, 8'h02, 1);
    addVec("t6_rst_hold",  0, 0, 0, 8'h02, 2, 8'h02, 0);

    // Reset-state check before the first record.
    @(posedge clk);
    #1;
    checkOutput("reset_state", 8'h00, 1'b0);

    runRange(0, mark_a);

    // Turning sticky off shows the (empty) debounced value at once.
    sticky_en = 1'b0;
    #1;
    checkOutput("t6_off_now", 8'h00, 1'b0);

    runRange(mark_a, mark_b);

    // Turning sticky back on shows the cleared latch at once.
    sticky_en = 1'b1;
    #1;
    checkOutput("t6_on_now", 8'h00, 1'b0);

    runRange(mark_b, vecs.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/priority_request_conditioner.md
Name: priority_request_conditioner

Overview:
Input-conditioning stage directly upstream of the 8-bit priority encoder / 7-segment decoder. Takes 8 raw asynchronous request lines (switches/buttons), synchronises and debounces each bit, and optionally latches requests until acknowledged. Its data_out drives the encoder's 8-bit data input (bit 7 highest priority). It also provides valid (any bit set) and a one-cycle changed strobe.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised level must hold before it is accepted; legal range 1..255; counter width = clog2(DEBOUNCE_CYCLES+1).

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset, synchronous, active-high
raw_in  input  8  asynchronous raw request lines
sticky_en  input  1  1 = latched-request mode, 0 = live debounced mode
ack  input  1  one-cycle pulse; clears the highest-priority latched request (sticky mode only)
data_out  output  8  conditioned requests to priority encoder
valid  output  1  |data_out
changed  output  1  registered one-cycle pulse when data_out differs from its previous-cycle value

Behaviour:
- Reset (rst=1 at a rising edge): sync stages, debounced state deb, per-bit counters, latch, previous-value register and changed all cleared to 0. Resulting outputs: data_out=0x00, valid=0, changed=0. rst overrides every other input, including mid-debounce and mid-latch.
- Synchroniser: two flops per bit (s1 <= raw_in, s2 <= s1).
- Debounce, per bit i, independent:
  - s2[i]==deb[i]: cnt[i] <= 0.
  - s2[i]!=deb[i] and cnt[i]==DEBOUNCE_CYCLES-1: deb[i] <= s2[i]; cnt[i] <= 0.
  - otherwise: cnt[i] <= cnt[i]+1.
  - Any return to equality before acceptance restarts the count; pulses shorter than DEBOUNCE_CYCLES sampled cycles are discarded.
  - Latency: a new stable raw level is visible on deb (and, in live mode, on data_out) after DEBOUNCE_CYCLES+2 rising edges, counted from the first edge that samples it. With default 4 this is 6 edges.
- Rise detect: rise[i] = deb becomes 1 at this edge (previous deb[i]=0, next deb[i]=1).
- Latch (sticky_en=1):
  - latch <= (latch & ~clr) | rise.
  - clr is the one-hot mask of the highest set bit of the current latch when ack=1, else 0.
  - Set wins over clear on the same bit in the same cycle.
  - ack with latch==0 has no effect.
  - Releasing an input does not clear its latch bit.
- Latch (sticky_en=0): latch <= 0 every edge and ack is ignored. Enabling sticky mode therefore starts from an empty latch; inputs already held high are not latched until they release and re-press.
- data_out = sticky_en ? latch : deb. It is a combinational mux of registers, with no extra cycle. Toggling sticky_en switches the source immediately.
- valid = |data_out, combinational.
- changed:
  - prev <= data_out every edge.
  - changed <= (data_out != prev), so it is a registered pulse one cycle after the change.
  - Held 0 in the cycle after reset.
  - A mode toggle that alters data_out also produces the pulse.
- Multiple bits may be accepted on the same edge; no priority is applied here (the encoder does that).

Test Plan:
1. Reset with raw_in=0xFF held, then release rst -> data_out=0x00, valid=0, changed=0 during reset; data_out=0xFF exactly 6 edges after the first post-reset edge; changed=1 for exactly one cycle, on the cycle after that.
2. Live mode, DEBOUNCE_CYCLES=4: raw_in 0x00->0x81 held -> data_out stays 0x00 for 5 edges, becomes 0x81 on edge 6; valid=1; single changed pulse.
3. Glitch rejection: raw_in[3] high for 3 cycles then low; separately, 10-cycle high with a 1-cycle low dropout at cycle 2 -> first case data_out never leaves 0x00; second case acceptance occurs 6 edges after the dropout ends.
4. Sticky mode: press/release bit5 then bit2 (each held 10 cycles) -> data_out=0x24. ack -> 0x04. ack -> 0x00 with valid=0. Third ack -> no change and no changed pulse.
5. Set/clear collision in sticky mode: latch=0x10, and bit4 is re-pressed so its rise lands on the same edge as ack -> data_out remains 0x10 and changed stays 0.
6. Mode/reset mid-operation: latch=0xC0, set sticky_en=0 with raw_in=0x00 -> data_out=0x00 immediately. Re-enable sticky -> data_out=0x00, and the latch stays empty. Assert rst during a half-counted debounce -> the count restarts from 0, with full 6-edge latency after reset.
